uart_tx_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one `uart_tx` transmitter among `P_REQ_NUM` byte-stream requesters. It sits between the user-side sources and the `uart_tx` valid/ready/data port. It locks the grant for a whole packet, delimited by `last`, so bytes from different sources never interleave on the line. A starvation timeout releases a grant whose owner stalls mid-packet.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART transmit path and its
// packet arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2
  } uart_arb_state_t;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_ODD  = 2'd1;
  localparam logic [1:0] PARITY_EVEN = 2'd2;

  // Ceiling log2, clamped to 1 so any width derived from it stays legal.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin search: first set request at or above the
// pointer, wrapping past the top requester back to zero.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int P_REQ_NUM = 4,
  parameter int P_PTR_W   = clog2(P_REQ_NUM)
) (
  input  logic [P_REQ_NUM-1:0] i_req,
  input  logic [P_PTR_W-1:0]   i_ptr,
  output logic [P_REQ_NUM-1:0] o_pick,
  output logic                 o_any
);

  // Both loops unroll, so every request bit is addressed by a constant index.
  always_comb begin
    logic w_found;
    w_found = 1'b0;
    o_pick  = '0;
    o_any   = |i_req;
    for (int i = 0; i < P_REQ_NUM; i++) begin
      for (int j = 0; j < P_REQ_NUM; j++) begin
        if (!w_found && i_req[j] && (j == ((int'(i_ptr) + i) % P_REQ_NUM))) begin
          o_pick[j] = 1'b1;
          w_found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart_tx among several
// byte-stream requesters, with a stall timeout on the current owner.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int P_REQ_NUM       = 4,
  parameter int P_DATA_WIDTH    = 8,
  parameter int P_STALL_TIMEOUT = 1000
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [P_REQ_NUM*P_DATA_WIDTH-1:0] i_req_data,
  input  logic [P_REQ_NUM-1:0]              i_req_valid,
  input  logic [P_REQ_NUM-1:0]              i_req_last,
  output logic [P_REQ_NUM-1:0]              o_req_ready,
  output logic [P_DATA_WIDTH-1:0]           o_tx_data,
  output logic                              o_tx_valid,
  input  logic                              i_tx_ready,
  output logic [P_REQ_NUM-1:0]              o_grant,
  output logic                              o_timeout
);

  localparam int                 L_PTR_W      = clog2(P_REQ_NUM);
  localparam int                 L_CNT_W      = clog2(P_STALL_TIMEOUT + 1);
  localparam bit                 L_TIMEOUT_EN = (P_STALL_TIMEOUT != 0);
  localparam logic [L_CNT_W-1:0] L_TIMEOUT    = L_CNT_W'(P_STALL_TIMEOUT);
  localparam logic [L_PTR_W-1:0] L_LAST_IDX   = L_PTR_W'(P_REQ_NUM - 1);

  uart_arb_state_t    r_state;
  logic [L_PTR_W-1:0] r_ptr;
  logic [L_CNT_W-1:0] r_stall_cnt;
  logic               r_last;

  logic [P_REQ_NUM-1:0]    w_pick;
  logic                    w_any;
  logic [L_PTR_W-1:0]      w_owner_idx;
  logic [L_PTR_W-1:0]      w_next_ptr;
  logic                    w_owner_valid;
  logic                    w_owner_last;
  logic [P_DATA_WIDTH-1:0] w_owner_data;

  uart_rr_pick #(
    .P_REQ_NUM (P_REQ_NUM),
    .P_PTR_W   (L_PTR_W)
  ) u_pick (
    .i_req  (i_req_valid),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_any  (w_any)
  );

  // The owner's lane is selected by the registered one-hot grant.
  always_comb begin
    w_owner_idx   = '0;
    w_owner_valid = 1'b0;
    w_owner_last  = 1'b0;
    w_owner_data  = '0;
    for (int k = 0; k < P_REQ_NUM; k++) begin
      if (o_grant[k]) begin
        w_owner_idx   = L_PTR_W'(k);
        w_owner_valid = i_req_valid[k];
        w_owner_last  = i_req_last[k];
        w_owner_data  = i_req_data[k*P_DATA_WIDTH +: P_DATA_WIDTH];
      end
    end
  end

  // After a release the previous owner drops to lowest priority.
  assign w_next_ptr  = (w_owner_idx == L_LAST_IDX) ? '0 : (w_owner_idx + L_PTR_W'(1));
  assign o_req_ready = (r_state == S_FETCH) ? o_grant : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_stall_cnt <= '0;
      r_last      <= 1'b0;
      o_grant     <= '0;
      o_tx_data   <= '0;
      o_tx_valid  <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_stall_cnt <= '0;
          if (w_any) begin
            o_grant <= w_pick;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          // A handshake takes precedence over an expiring stall count.
          if (w_owner_valid) begin
            o_tx_data   <= w_owner_data;
            r_last      <= w_owner_last;
            o_tx_valid  <= 1'b1;
            r_stall_cnt <= '0;
            r_state     <= S_SEND;
          end else if (L_TIMEOUT_EN) begin
            if (r_stall_cnt == L_TIMEOUT) begin
              o_timeout   <= 1'b1;
              r_ptr       <= w_next_ptr;
              o_grant     <= '0;
              r_stall_cnt <= '0;
              r_state     <= S_IDLE;
            end else begin
              r_stall_cnt <= r_stall_cnt + L_CNT_W'(1);
            end
          end
        end
        S_SEND: begin
          // Leaving SEND on accept guarantees a low valid cycle after it.
          if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
            if (r_last) begin
              r_ptr   <= w_next_ptr;
              o_grant <= '0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          o_grant    <= '0;
          o_tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter: per-requester byte
// buffers feed the DUT and every accepted byte is logged for checking.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 1000;

  logic         clk = 1'b0;
  logic         rst;
  logic [N*W-1:0] reqData;
  logic [N-1:0] reqValid;
  logic [N-1:0] reqLast;
  logic [N-1:0] reqReady;
  logic [W-1:0] txData;
  logic         txValid;
  logic         txReady;
  logic [N-1:0] grant;
  logic         timeoutPulse;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .P_REQ_NUM       (N),
    .P_DATA_WIDTH    (W),
    .P_STALL_TIMEOUT (TO)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_data  (reqData),
    .i_req_valid (reqValid),
    .i_req_last  (reqLast),
    .o_req_ready (reqReady),
    .o_tx_data   (txData),
    .o_tx_valid  (txValid),
    .i_tx_ready  (txReady),
    .o_grant     (grant),
    .o_timeout   (timeoutPulse)
  );

  int compared = 0;
  int mismatched = 0;

  logic [7:0] srcByte [N][16];
  logic       srcLast [N][16];
  int         srcLen  [N];
  int         srcPos  [N];
  int         holdAt  [N];

  logic [7:0]   logData  [64];
  logic [N-1:0] logGrant [64];
  int           logCycle [64];
  int           logCount = 0;

  int cycleCount = 0;
  int busyLen = 0;
  int busyCnt = 0;
  int timeoutCount = 0;
  bit txForceLow = 1'b0;
  bit prevAccept = 1'b0;
  int base;
  int steps;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Present each requester's current buffered byte, unless it is holding.
  task automatic driveSources();
    for (int k = 0; k < N; k++) begin
      if (srcPos[k] < srcLen[k] && srcPos[k] != holdAt[k]) begin
        reqValid[k]          = 1'b1;
        reqData[k*W +: W]    = srcByte[k][srcPos[k]];
        reqLast[k]           = srcLast[k][srcPos[k]];
      end else begin
        reqValid[k]          = 1'b0;
        reqData[k*W +: W]    = '0;
        reqLast[k]           = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input int k, input logic [7:0] b, input logic last);
    srcByte[k][srcLen[k]] = b;
    srcLast[k][srcLen[k]] = last;
    srcLen[k]++;
    driveSources();
  endtask

  task automatic clearSources();
    for (int k = 0; k < N; k++) begin
      srcLen[k] = 0;
      srcPos[k] = 0;
      holdAt[k] = -1;
    end
    driveSources();
  endtask

  // Observe at the falling edge, then advance to just after the rising edge.
  task automatic stepCycle();
    bit accepted;
    @(negedge clk);
    cycleCount++;
    accepted = 1'b0;
    if (!rst) begin
      checkOutput("readyOnlyOwner", reqReady & ~grant, 0);
      if (prevAccept) checkOutput("gapAfterAccept", txValid, 0);
      if (timeoutPulse) timeoutCount++;
      for (int k = 0; k < N; k++)
        if (reqValid[k] && reqReady[k]) srcPos[k]++;
      if (txValid && txReady) begin
        accepted = 1'b1;
        if (logCount < 64) begin
          logData[logCount]  = txData;
          logGrant[logCount] = grant;
          logCycle[logCount] = cycleCount;
        end
        logCount++;
      end
    end
    prevAccept = accepted;
    @(posedge clk);
    #1;
    if (accepted && busyLen > 0) busyCnt = busyLen;
    else if (busyCnt > 0) busyCnt--;
    txReady = !txForceLow && (busyCnt == 0);
    driveSources();
  endtask

  task automatic doReset();
    rst = 1'b1;
    busyLen = 0;
    busyCnt = 0;
    txForceLow = 1'b0;
    txReady = 1'b1;
    clearSources();
    stepCycle();
    stepCycle();
    rst = 1'b0;
  endtask

  task automatic waitAccepts(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (logCount < target && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput(tag, logCount, target);
  endtask

  task automatic checkLog(input int idx, input logic [7:0] expData, input logic [N-1:0] expGrant, input string tag);
    checkOutput({tag, "Data"}, logData[idx], expData);
    checkOutput({tag, "Grant"}, logGrant[idx], expGrant);
  endtask

  initial begin
    rst = 1'b1;
    txReady = 1'b1;
    reqValid = '0;
    reqData = '0;
    reqLast = '0;
    clearSources();
    stepCycle();
    stepCycle();
    checkOutput("rstGrant", grant, 0);
    checkOutput("rstReady", reqReady, 0);
    checkOutput("rstTxValid", txValid, 0);
    checkOutput("rstTxData", txData, 0);
    checkOutput("rstTimeout", timeoutPulse, 0);
    rst = 1'b0;

    // Single requester with a slow downstream; also pins first-byte latency.
    base = logCount;
    busyLen = 5;
    applyStimulus(0, 8'h55, 1'b0);
    applyStimulus(0, 8'hA3, 1'b1);
    stepCycle();
    checkOutput("latGrant", grant, 4'b0001);
    checkOutput("latReady", reqReady, 4'b0001);
    checkOutput("latTxValidLow", txValid, 0);
    stepCycle();
    checkOutput("sendValid", txValid, 1);
    checkOutput("sendData", txData, 8'h55);
    checkOutput("sendReadyLow", reqReady, 0);
    stepCycle();
    checkOutput("postAcceptValid", txValid, 0);
    checkOutput("refetchReady", reqReady, 4'b0001);
    waitAccepts(base + 2, 200, "singleDone");
    checkLog(base, 8'h55, 4'b0001, "single0");
    checkLog(base + 1, 8'hA3, 4'b0001, "single1");
    checkOutput("singleGrantIdle", grant, 0);

    // All four requesters from reset, ready held high throughout.
    doReset();
    base = logCount;
    for (int k = 0; k < N; k++) begin
      applyStimulus(k, 8'(8'hA0 + k), 1'b0);
      applyStimulus(k, 8'(8'hB0 + k), 1'b1);
    end
    waitAccepts(base + 8, 200, "allDone");
    for (int k = 0; k < N; k++) begin
      checkLog(base + 2*k, 8'(8'hA0 + k), 4'(1 << k), "allFirst");
      checkLog(base + 2*k + 1, 8'(8'hB0 + k), 4'(1 << k), "allSecond");
    end
    checkOutput("b2bByteSpacing", logCycle[base+1] - logCycle[base], 2);
    checkOutput("b2bPacketSpacing", logCycle[base+2] - logCycle[base+1], 3);

    // Requester 0 re-requests while 1 waits; 1 goes first.
    base = logCount;
    applyStimulus(0, 8'hC0, 1'b1);
    applyStimulus(0, 8'hD0, 1'b1);
    applyStimulus(1, 8'hC1, 1'b1);
    waitAccepts(base + 3, 100, "fairDone");
    checkLog(base, 8'hC0, 4'b0001, "fair0");
    checkLog(base + 1, 8'hC1, 4'b0010, "fair1");
    checkLog(base + 2, 8'hD0, 4'b0001, "fair2");

    // Owner 2 stalls after its first byte while 3 is pending.
    doReset();
    base = logCount;
    timeoutCount = 0;
    holdAt[2] = 1;
    applyStimulus(2, 8'h11, 1'b0);
    applyStimulus(2, 8'h12, 1'b1);
    applyStimulus(3, 8'h33, 1'b1);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("stallFirstByte", logCount, base + 1);
    checkOutput("stallOwner", grant, 4'b0100);
    steps = 0;
    while (!timeoutPulse && steps < TO + 100) begin
      stepCycle();
      steps++;
    end
    checkOutput("stallTimeoutCycles", steps, TO + 1);
    checkOutput("stallReleased", grant, 0);
    srcLen[2] = srcPos[2];
    holdAt[2] = -1;
    driveSources();
    stepCycle();
    checkOutput("timeoutOneCycle", timeoutPulse, 0);
    checkOutput("pendingGranted", grant, 4'b1000);
    waitAccepts(base + 2, 50, "stallDone");
    checkLog(base + 1, 8'h33, 4'b1000, "stallNext");
    checkOutput("timeoutCount", timeoutCount, 1);

    // Reset while in SEND with the pointer sitting at 1.
    doReset();
    base = logCount;
    applyStimulus(0, 8'h71, 1'b1);
    waitAccepts(base + 1, 50, "preRstDone");
    txForceLow = 1'b1;
    txReady = 1'b0;
    applyStimulus(1, 8'h81, 1'b0);
    applyStimulus(1, 8'h82, 1'b1);
    steps = 0;
    while (!txValid && steps < 20) begin
      stepCycle();
      steps++;
    end
    checkOutput("midPacketSend", txValid, 1);
    checkOutput("midPacketData", txData, 8'h81);
    rst = 1'b1;
    applyStimulus(0, 8'h90, 1'b1);
    stepCycle();
    checkOutput("midRstGrant", grant, 0);
    checkOutput("midRstReady", reqReady, 0);
    checkOutput("midRstTxValid", txValid, 0);
    checkOutput("midRstTxData", txData, 0);
    checkOutput("midRstTimeout", timeoutPulse, 0);
    rst = 1'b0;
    txForceLow = 1'b0;
    busyCnt = 0;
    txReady = 1'b1;
    stepCycle();
    checkOutput("rstPtrWinner", grant, 4'b0001);
    waitAccepts(base + 3, 50, "postRstDone");
    checkLog(base + 1, 8'h90, 4'b0001, "postRst0");
    checkLog(base + 2, 8'h82, 4'b0010, "postRst1");

    // Single-byte packets from 1 and 3 with the pointer at 2.
    base = logCount;
    applyStimulus(1, 8'h1A, 1'b1);
    applyStimulus(3, 8'h3A, 1'b1);
    waitAccepts(base + 1, 50, "oneByteFirst");
    checkOutput("oneByteIdle", grant, 0);
    waitAccepts(base + 2, 50, "oneByteSecond");
    checkLog(base, 8'h3A, 4'b1000, "oneByte0");
    checkLog(base + 1, 8'h1A, 4'b0010, "oneByte1");
    checkOutput("oneByteFinalIdle", grant, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
